// File: rtl/neuron_loader_if.sv
// Handshake bundle between the upstream beat source, the neuron loader and the neuron stage.
// Optional in_last/frame_err exist only when NEURON_LOADER_LAST_CHECK_EN is defined.
interface neuron_loader_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  localparam int IW = $clog2(N + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_x;
  logic [WIDTH-1:0]     in_w;
  logic [WIDTH-1:0]     in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [N*WIDTH-1:0]   x_out;
  logic [N*WIDTH-1:0]   w_out;
  logic [WIDTH-1:0]     b_out;
  logic [IW-1:0]        idx;
`ifdef NEURON_LOADER_LAST_CHECK_EN
  logic                 in_last;
  logic                 frame_err;

  modport master (
    output in_valid, in_x, in_w, in_b, out_ready, in_last,
    input  in_ready, out_valid, x_out, w_out, b_out, idx, frame_err
  );
  modport slave (
    input  in_valid, in_x, in_w, in_b, out_ready, in_last,
    output in_ready, out_valid, x_out, w_out, b_out, idx, frame_err
  );
`else
  modport master (
    output in_valid, in_x, in_w, in_b, out_ready,
    input  in_ready, out_valid, x_out, w_out, b_out, idx
  );
  modport slave (
    input  in_valid, in_x, in_w, in_b, out_ready,
    output in_ready, out_valid, x_out, w_out, b_out, idx
  );
`endif
endinterface

// File: rtl/neuron_loader.sv
// Collects N x/w beats plus a bias into a held vector for the neuron stage.
// Optional framing check on in_last is enabled by NEURON_LOADER_LAST_CHECK_EN.
module neuron_loader #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  neuron_loader_if.slave  bus
);
  localparam int IW = $clog2(N + 1);
  localparam logic [0:0] LOAD = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  logic [0:0]         state_r;
  logic [IW-1:0]      idx_r;
  logic [N*WIDTH-1:0] x_r;
  logic [N*WIDTH-1:0] w_r;
  logic [WIDTH-1:0]   b_r;
  logic               last_beat_s;
  logic               accept_s;
  logic               err_s;
`ifdef NEURON_LOADER_LAST_CHECK_EN
  logic               frame_err_r;
`endif

  assign last_beat_s = (idx_r == IW'(N - 1));

  // Classify the current input beat as accepted, framing error, or nothing.
  always_comb begin
    accept_s = 1'b0;
    err_s    = 1'b0;
    if ((state_r == LOAD) && bus.in_valid) begin
`ifdef NEURON_LOADER_LAST_CHECK_EN
      if (bus.in_last != last_beat_s) begin
        err_s = 1'b1;
      end else begin
        accept_s = 1'b1;
      end
`else
      accept_s = 1'b1;
`endif
    end else begin
      accept_s = 1'b0;
      err_s    = 1'b0;
    end
  end

  // State, beat counter and vector storage; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= LOAD;
      idx_r   <= IW'(0);
      x_r     <= '0;
      w_r     <= '0;
      b_r     <= {WIDTH{1'b0}};
`ifdef NEURON_LOADER_LAST_CHECK_EN
      frame_err_r <= 1'b0;
`endif
    end else begin
`ifdef NEURON_LOADER_LAST_CHECK_EN
      frame_err_r <= err_s;
`endif
      case (state_r)
        LOAD: begin
          if (err_s) begin
            idx_r <= IW'(0);
          end else if (accept_s) begin
            for (int i = 0; i < N; i++) begin
              if (idx_r == IW'(i)) begin
                x_r[i*WIDTH +: WIDTH] <= bus.in_x;
                w_r[i*WIDTH +: WIDTH] <= bus.in_w;
              end
            end
            if (idx_r == IW'(0)) begin
              b_r <= bus.in_b;
            end
            // idx reads N while the vector is held.
            idx_r <= idx_r + IW'(1);
            if (last_beat_s) begin
              state_r <= FULL;
            end
          end else begin
            idx_r <= idx_r;
          end
        end
        FULL: begin
          if (bus.out_ready) begin
            state_r <= LOAD;
            idx_r   <= IW'(0);
          end
        end
        default: begin
          state_r <= LOAD;
          idx_r   <= IW'(0);
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_r == LOAD);
  assign bus.out_valid = (state_r == FULL);
  assign bus.x_out     = x_r;
  assign bus.w_out     = w_r;
  assign bus.b_out     = b_r;
  assign bus.idx       = idx_r;
`ifdef NEURON_LOADER_LAST_CHECK_EN
  assign bus.frame_err = frame_err_r;
`endif

endmodule

// File: doc/neuron_loader.md
NEURON_LOADER -- requirements
Module: neuron_loader

Interface
REQ-001 Parameter N, default 4, number of neuron inputs (N >= 1).
REQ-002 Parameter WIDTH, default 8, signed width of each x, w and b element.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream beat valid.
REQ-006 in_ready  output  1  loader accepts a beat this cycle.
REQ-007 in_x  input  WIDTH  signed input sample for the current index.
REQ-008 in_w  input  WIDTH  signed weight for the current index.
REQ-009 in_b  input  WIDTH  signed bias, sampled only on beat 0.
REQ-010 out_valid  output  1  complete x/w/b vector held for the neuron stage.
REQ-011 out_ready  input  1  downstream consumer takes the vector.
REQ-012 x_out  output  N*WIDTH  packed x vector, element i at bits [i*WIDTH +: WIDTH].
REQ-013 w_out  output  N*WIDTH  packed w vector, same packing as x_out.
REQ-014 b_out  output  WIDTH  latched bias.
REQ-015 idx  output  clog2(N+1)  number of beats accepted in the current frame.

Function
REQ-016 Two states: LOAD (collecting beats) and FULL (vector presented); the loader SHALL use exactly these two.
REQ-017 in_ready SHALL equal 1 in LOAD and 0 in FULL; out_valid SHALL equal 1 in FULL and 0 in LOAD.
REQ-018 A beat is accepted when in_valid && in_ready; accepted beat k SHALL write in_x/in_w to element k and increment idx.
REQ-019 On beat 0 the loader SHALL also latch in_b into b_out; in_b on other beats SHALL be ignored.
REQ-020 On acceptance of beat N-1 the loader SHALL enter FULL on the next edge; out_valid rises exactly 1 cycle after the last beat.
REQ-021 In FULL, x_out, w_out and b_out SHALL remain stable until out_valid && out_ready.
REQ-022 On out_valid && out_ready the loader SHALL return to LOAD with idx = 0 on the next edge; no beat is accepted in that cycle.
REQ-023 in_valid low in LOAD SHALL hold idx and stored elements unchanged (bubbles allowed between beats).
REQ-024 Input values are stored bit-exact; no arithmetic, saturation or sign change.
REQ-025 N = 1: every accepted beat SHALL move LOAD to FULL directly.

Reset
REQ-026 While rst = 1 at a clock edge: state = LOAD, idx = 0, out_valid = 0, in_ready = 1 after the edge, x_out = w_out = 0, b_out = 0.
REQ-027 rst SHALL take priority over any handshake in the same cycle, discarding a partial frame or a held vector.

Configuration
REQ-028 Macro NEURON_LOADER_LAST_CHECK_EN: when defined, an input in_last (1 bit) and output frame_err (1 bit) SHALL exist.
REQ-029 With the macro: an accepted beat with in_last mismatching (k == N-1) SHALL pulse frame_err for 1 cycle, clear idx to 0 and stay in LOAD; frame_err resets to 0.
REQ-030 Without the macro: in_last and frame_err SHALL not exist and framing is determined by beat count only.

Verification
REQ-031 Reset then 4 beats x=1,2,3,4, w=1,1,1,1, b=5 on beat 0 with out_ready=0 -> out_valid 1 cycle after beat 3, x_out=0x04030201, w_out=0x01010101, b_out=5, held 10 cycles.
REQ-032 Same frame, then out_ready=1 for 1 cycle -> out_valid=0, in_ready=1, idx=0 next cycle; second frame x=-5,3,-2,1 loads correctly (x_out=0x01FE03FB).
REQ-033 in_valid toggled 1/0 per cycle during a frame -> only valid beats counted, out_valid after 4th accepted beat.
REQ-034 rst asserted after 2 beats, then full frame x=2,2,2,2, w=-1x4, b=-1 -> no stale data, x_out=0x02020202, w_out=0xFFFFFFFF, b_out=0xFF.
REQ-035 in_valid held 1 in FULL with changing in_x -> x_out unchanged, no beat accepted until after release.
REQ-036 With NEURON_LOADER_LAST_CHECK_EN: in_last=1 on beat 1 -> frame_err pulse 1 cycle, idx=0, out_valid stays 0.
